hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard unit for a five-stage in-order core.
//
// Purpose:
//   Decides, every cycle, how the pipeline registers move: normal advance,
//   load-use / data-hazard bubble, branch redirect flush, or a full freeze
//   while data memory is busy. Also selects EX operand forwarding sources
//   and keeps stall / flush performance counters and a sticky memory
//   timeout flag.
//
// Parameters:
//   FWD_EN  : 1 = forwarding pipeline, 0 = stall-only pipeline
//   TIMEOUT : data-memory wait limit in cycles (1..65535)
//   CNT_W   : performance counter width
//
// Ports:
//   i_clk, i_rst            : clock (rising edge), synchronous active-high reset
//   i_ID_inst, i_rs1_en,
//   i_rs2_en                : ID instruction and which sources it reads
//   i_EX_*                  : EX instruction, its rd write, source reads, load flag
//   i_MEM_inst, i_MEM_rd_wren,
//   i_MEM_mem_acc           : MEM instruction, rd write, data-memory access
//   i_WB_inst, i_WB_rd_wren : WB instruction and rd write
//   i_br_taken              : EX-stage redirect
//   i_dmem_ready            : data memory finishes the access this cycle
//   o_pc_en .. o_MEM_WB_flush : pipeline register controls (combinational)
//   o_fwd_a, o_fwd_b        : EX rs1/rs2 source, 00 = RF, 01 = MEM, 10 = WB
//   o_mem_timeout           : sticky timeout flag (registered)
//   o_stall_cnt, o_flush_cnt: saturating performance counters (registered)
//   o_dbg_state             : current FSM state, 0 = S_RUN, 1 = S_MEM_WAIT
//
// Memory handshake: the MEM stage holds i_MEM_mem_acc high for as long as
// its access is outstanding; the access completes in the cycle where
// i_dmem_ready is also high. Any cycle with i_MEM_mem_acc=1 and
// i_dmem_ready=0 is a wait cycle and freezes the whole pipeline.

module hazard_ctrl #(
    parameter int FWD_EN  = 1,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_ID_inst,
    input  logic             i_rs1_en,
    input  logic             i_rs2_en,
    input  logic [31:0]      i_EX_inst,
    input  logic             i_EX_rd_wren,
    input  logic             i_EX_rs1_en,
    input  logic             i_EX_rs2_en,
    input  logic             i_EX_mem_rd,
    input  logic [31:0]      i_MEM_inst,
    input  logic             i_MEM_rd_wren,
    input  logic             i_MEM_mem_acc,
    input  logic [31:0]      i_WB_inst,
    input  logic             i_WB_rd_wren,
    input  logic             i_br_taken,
    input  logic             i_dmem_ready,
    output logic             o_pc_en,
    output logic             o_IF_ID_stall,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_stall,
    output logic             o_ID_EX_flush,
    output logic             o_EX_MEM_stall,
    output logic             o_MEM_WB_flush,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_dbg_state
);

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    localparam logic              FWD        = (FWD_EN != 0);
    localparam int                WAIT_W     = 16;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    localparam logic [1:0] SRC_RF  = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_WB  = 2'b10;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] mem_rd;
    logic [4:0] wb_rd;

    assign id_rs1 = i_ID_inst[19:15];
    assign id_rs2 = i_ID_inst[24:20];
    assign ex_rd  = i_EX_inst[11:7];
    assign ex_rs1 = i_EX_inst[19:15];
    assign ex_rs2 = i_EX_inst[24:20];
    assign mem_rd = i_MEM_inst[11:7];
    assign wb_rd  = i_WB_inst[11:7];

    // Opcode / funct / immediate bits play no part in hazard decisions.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{i_ID_inst[31:25], i_ID_inst[14:0],
                                i_EX_inst[31:25], i_EX_inst[14:12], i_EX_inst[6:0],
                                i_MEM_inst[31:12], i_MEM_inst[6:0],
                                i_WB_inst[31:12], i_WB_inst[6:0]};

    // A producer matches a consumer source when the source is really read,
    // the producer really writes, and the register is not the hardwired x0.
    function automatic logic src_match(input logic       src_en,
                                       input logic [4:0] src,
                                       input logic       wren,
                                       input logic [4:0] rd);
        return src_en && wren && (rd != 5'd0) && (rd == src);
    endfunction

    // MEM is checked first so the youngest value wins.
    function automatic logic [1:0] fwd_sel(input logic       src_en,
                                           input logic [4:0] src,
                                           input logic       mem_wren,
                                           input logic [4:0] mem_dst,
                                           input logic       wb_wren,
                                           input logic [4:0] wb_dst);
        if (src_match(src_en, src, mem_wren, mem_dst)) begin
            return SRC_MEM;
        end
        if (src_match(src_en, src, wb_wren, wb_dst)) begin
            return SRC_WB;
        end
        return SRC_RF;
    endfunction

    // ------------------------------------------------------------------
    // Hazard conditions
    // ------------------------------------------------------------------
    logic ex_hit;
    logic mem_hit;
    logic data_hazard;
    logic mem_wait;
    logic branch_act;

    assign ex_hit  = src_match(i_rs1_en, id_rs1, i_EX_rd_wren, ex_rd) ||
                     src_match(i_rs2_en, id_rs2, i_EX_rd_wren, ex_rd);
    assign mem_hit = src_match(i_rs1_en, id_rs1, i_MEM_rd_wren, mem_rd) ||
                     src_match(i_rs2_en, id_rs2, i_MEM_rd_wren, mem_rd);

    // With forwarding only a load in EX cannot supply its result in time.
    // Without it, any in-flight writer in EX or MEM blocks ID; WB is safe
    // because the register file writes before it is read.
    assign data_hazard = FWD ? (i_EX_mem_rd && ex_hit) : (ex_hit || mem_hit);

    assign mem_wait = i_MEM_mem_acc && !i_dmem_ready;

    // A branch during a memory wait stays parked in EX and only fires once
    // memory completes, so it is masked by mem_wait here.
    assign branch_act = i_br_taken && !mem_wait && !i_rst;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (mem_wait) begin
                    state_next = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (i_dmem_ready || !i_MEM_mem_acc) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Priority: reset, memory wait, branch, data hazard.
    // The freeze follows the live wait condition so the pipeline stops in
    // the very first wait cycle, before the FSM has registered S_MEM_WAIT.
    // ------------------------------------------------------------------
    always_comb begin
        o_pc_en        = 1'b1;
        o_IF_ID_stall  = 1'b0;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_stall  = 1'b0;
        o_ID_EX_flush  = 1'b0;
        o_EX_MEM_stall = 1'b0;
        o_MEM_WB_flush = 1'b0;

        if (i_rst) begin
            o_pc_en        = 1'b0;
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
            o_MEM_WB_flush = 1'b1;
        end else if (mem_wait) begin
            o_pc_en        = 1'b0;
            o_IF_ID_stall  = 1'b1;
            o_ID_EX_stall  = 1'b1;
            o_EX_MEM_stall = 1'b1;
            o_MEM_WB_flush = 1'b1;
        end else if (i_br_taken) begin
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
        end else if (data_hazard) begin
            o_pc_en        = 1'b0;
            o_IF_ID_stall  = 1'b1;
            o_ID_EX_flush  = 1'b1;
        end
    end

    assign o_dbg_state = state;

    // ------------------------------------------------------------------
    // Forwarding select
    // ------------------------------------------------------------------
    always_comb begin
        o_fwd_a = SRC_RF;
        o_fwd_b = SRC_RF;
        if (FWD && !i_rst) begin
            o_fwd_a = fwd_sel(i_EX_rs1_en, ex_rs1, i_MEM_rd_wren, mem_rd,
                              i_WB_rd_wren, wb_rd);
            o_fwd_b = fwd_sel(i_EX_rs2_en, ex_rs2, i_MEM_rd_wren, mem_rd,
                              i_WB_rd_wren, wb_rd);
        end
    end

    // ------------------------------------------------------------------
    // Wait counter, timeout flag, performance counters
    // ------------------------------------------------------------------
    // wait_cnt counts consecutive wait edges, including the edge that enters
    // S_MEM_WAIT, and drops to zero on any edge that lands in S_RUN. Once it
    // sits at the limit the sticky flag is raised on the following edge.
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              mem_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (state_next == S_RUN) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (wait_cnt == WAIT_LIMIT) begin
                mem_timeout <= 1'b1;
            end

            if (!o_pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (branch_act && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_mem_timeout = mem_timeout;
    assign o_stall_cnt   = stall_cnt;
    assign o_flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- bench for hazard_ctrl.
// Two instances share one set of inputs:
//   dut_f : forwarding pipeline, TIMEOUT=4, 32-bit counters
//   dut_s : stall-only pipeline, TIMEOUT=6, 4-bit counters (saturation)
// Control outputs are packed per instance as
//   {pc_en, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
//    EX_MEM_stall, MEM_WB_flush, fwd_a[1:0], fwd_b[1:0]}.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int TO_F = 4;
  localparam int TO_S = 6;

  localparam logic [10:0] V_IDLE   = {1'b1, 6'b000000, 4'b0000};
  localparam logic [10:0] V_RST    = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
  localparam logic [10:0] V_FREEZE = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000};
  localparam logic [10:0] V_BRANCH = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
  localparam logic [10:0] V_STALL  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus ----------------
  logic [31:0] id_inst, ex_inst, mem_inst, wb_inst;
  logic rs1_en, rs2_en, ex_wren, ex_rs1_en, ex_rs2_en, ex_mem_rd;
  logic mem_wren, mem_acc, wb_wren, br_taken, dmem_ready;

  // ---------------- DUT outputs ----------------
  wire [10:0] ctrl_f, ctrl_s;
  wire [31:0] scnt_f, fcnt_f;
  wire [3:0]  scnt_s, fcnt_s;
  wire        to_f, to_s, st_f, st_s;

  hazard_ctrl #(.FWD_EN(1), .TIMEOUT(TO_F), .CNT_W(32)) dut_f (
    .i_clk(clk), .i_rst(rst),
    .i_ID_inst(id_inst), .i_rs1_en(rs1_en), .i_rs2_en(rs2_en),
    .i_EX_inst(ex_inst), .i_EX_rd_wren(ex_wren), .i_EX_rs1_en(ex_rs1_en),
    .i_EX_rs2_en(ex_rs2_en), .i_EX_mem_rd(ex_mem_rd),
    .i_MEM_inst(mem_inst), .i_MEM_rd_wren(mem_wren), .i_MEM_mem_acc(mem_acc),
    .i_WB_inst(wb_inst), .i_WB_rd_wren(wb_wren),
    .i_br_taken(br_taken), .i_dmem_ready(dmem_ready),
    .o_pc_en(ctrl_f[10]), .o_IF_ID_stall(ctrl_f[9]), .o_IF_ID_flush(ctrl_f[8]),
    .o_ID_EX_stall(ctrl_f[7]), .o_ID_EX_flush(ctrl_f[6]),
    .o_EX_MEM_stall(ctrl_f[5]), .o_MEM_WB_flush(ctrl_f[4]),
    .o_fwd_a(ctrl_f[3:2]), .o_fwd_b(ctrl_f[1:0]),
    .o_mem_timeout(to_f), .o_stall_cnt(scnt_f), .o_flush_cnt(fcnt_f),
    .o_dbg_state(st_f)
  );

  hazard_ctrl #(.FWD_EN(0), .TIMEOUT(TO_S), .CNT_W(4)) dut_s (
    .i_clk(clk), .i_rst(rst),
    .i_ID_inst(id_inst), .i_rs1_en(rs1_en), .i_rs2_en(rs2_en),
    .i_EX_inst(ex_inst), .i_EX_rd_wren(ex_wren), .i_EX_rs1_en(ex_rs1_en),
    .i_EX_rs2_en(ex_rs2_en), .i_EX_mem_rd(ex_mem_rd),
    .i_MEM_inst(mem_inst), .i_MEM_rd_wren(mem_wren), .i_MEM_mem_acc(mem_acc),
    .i_WB_inst(wb_inst), .i_WB_rd_wren(wb_wren),
    .i_br_taken(br_taken), .i_dmem_ready(dmem_ready),
    .o_pc_en(ctrl_s[10]), .o_IF_ID_stall(ctrl_s[9]), .o_IF_ID_flush(ctrl_s[8]),
    .o_ID_EX_stall(ctrl_s[7]), .o_ID_EX_flush(ctrl_s[6]),
    .o_EX_MEM_stall(ctrl_s[5]), .o_MEM_WB_flush(ctrl_s[4]),
    .o_fwd_a(ctrl_s[3:2]), .o_fwd_b(ctrl_s[1:0]),
    .o_mem_timeout(to_s), .o_stall_cnt(scnt_s), .o_flush_cnt(fcnt_s),
    .o_dbg_state(st_s)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] exp_q[$];

  // ---------------- reference model state ----------------
  int     fwd_m [2] = '{1, 0};
  int     to_m  [2] = '{TO_F, TO_S};
  longint cmax  [2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
  int     run_m [2];   // consecutive wait edges seen
  bit     flag_m[2];
  longint scnt_m[2];
  longint fcnt_m[2];
  bit     st_m  [2];   // 1 = the previous edge was a wait edge

  function automatic logic [31:0] mk_inst(input int rd, input int rs1, input int rs2);
    logic [31:0] v;
    v = $urandom;
    v[11:7]  = 5'(rd);
    v[19:15] = 5'(rs1);
    v[24:20] = 5'(rs2);
    return v;
  endfunction

  // Does the ID instruction read a register the given producer will write?
  function automatic bit id_needs(input logic [31:0] prod, input logic wren);
    int dst;
    dst = int'(prod[11:7]);
    if (!wren || dst == 0) return 1'b0;
    return (rs1_en && int'(id_inst[19:15]) == dst) || (rs2_en && int'(id_inst[24:20]) == dst);
  endfunction

  // Where should an EX operand come from: youngest writer of that register.
  function automatic logic [1:0] src_of(input logic en, input logic [4:0] r);
    logic [4:0] md, wd;
    md = mem_inst[11:7];
    wd = wb_inst[11:7];
    if (!en || r == 5'd0) return 2'b00;
    if (mem_wren && md == r) return 2'b01;
    if (wb_wren && wd == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [10:0] exp_ctrl(input int k);
    logic       waiting, hz;
    logic [3:0] fw;
    logic [4:0] r1, r2;
    waiting = mem_acc && !dmem_ready;
    if (fwd_m[k] != 0) hz = ex_mem_rd && id_needs(ex_inst, ex_wren);
    else               hz = id_needs(ex_inst, ex_wren) || id_needs(mem_inst, mem_wren);
    r1 = ex_inst[19:15];
    r2 = ex_inst[24:20];
    fw = (fwd_m[k] != 0) ? {src_of(ex_rs1_en, r1), src_of(ex_rs2_en, r2)} : 4'b0000;
    if (rst)           return V_RST;
    if (waiting)       return {V_FREEZE[10:4], fw};
    if (br_taken)      return {V_BRANCH[10:4], fw};
    if (hz)            return {V_STALL[10:4], fw};
    return {V_IDLE[10:4], fw};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run_m[k] = 0; flag_m[k] = 1'b0; scnt_m[k] = 0; fcnt_m[k] = 0; st_m[k] = 1'b0;
    end
  endtask

  // Advance one rising edge and let the model follow.
  task automatic tick();
    logic [10:0] e[2];
    logic waiting;
    e[0] = exp_ctrl(0);
    e[1] = exp_ctrl(1);
    waiting = mem_acc && !dmem_ready;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        run_m[k] = 0; flag_m[k] = 1'b0; scnt_m[k] = 0; fcnt_m[k] = 0; st_m[k] = 1'b0;
      end else begin
        if (run_m[k] >= to_m[k]) flag_m[k] = 1'b1;
        run_m[k] = waiting ? run_m[k] + 1 : 0;
        if (!e[k][10] && scnt_m[k] < cmax[k]) scnt_m[k]++;
        if (br_taken && !waiting && fcnt_m[k] < cmax[k]) fcnt_m[k]++;
        st_m[k] = waiting;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    id_inst = 32'h0000_0013; ex_inst = 32'h0000_0013;
    mem_inst = 32'h0000_0013; wb_inst = 32'h0000_0013;
    rs1_en = 0; rs2_en = 0; ex_wren = 0; ex_rs1_en = 0; ex_rs2_en = 0; ex_mem_rd = 0;
    mem_wren = 0; mem_acc = 0; wb_wren = 0; br_taken = 0; dmem_ready = 1;
  endtask

  task automatic drive_load_use();
    ex_inst = mk_inst(5, 1, 2); ex_wren = 1; ex_mem_rd = 1;   // lw x5
    id_inst = mk_inst(6, 5, 7); rs1_en = 1; rs2_en = 1;       // add x6,x5,x7
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    mem_acc = 1; dmem_ready = 0; br_taken = 1; drive_load_use();
    #1;
    n_checks++; if (ctrl_f !== V_RST) begin n_fail++; $display("FAIL reset_ctrl_f: got %b expected %b", ctrl_f, V_RST); end
    n_checks++; if (ctrl_s !== V_RST) begin n_fail++; $display("FAIL reset_ctrl_s: got %b expected %b", ctrl_s, V_RST); end
    n_checks++; if (scnt_f !== 32'd0 || fcnt_f !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", scnt_f, fcnt_f); end
    n_checks++; if (to_f !== 1'b0 || st_f !== 1'b0) begin n_fail++; $display("FAIL reset_flag_state: got %b/%b expected 0/0", to_f, st_f); end
    tick();
    @(negedge clk);
    rst = 0; drive_idle();
    #1;
    n_checks++; if (ctrl_f !== V_IDLE) begin n_fail++; $display("FAIL idle_ctrl_f: got %b expected %b", ctrl_f, V_IDLE); end
    n_checks++; if (ctrl_s !== V_IDLE) begin n_fail++; $display("FAIL idle_ctrl_s: got %b expected %b", ctrl_s, V_IDLE); end
    tick();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_idle(); drive_load_use();
    #1;
    n_checks++; if (ctrl_f !== V_STALL) begin n_fail++; $display("FAIL load_use_ctrl_f: got %b expected %b", ctrl_f, V_STALL); end
    n_checks++; if (ctrl_s !== V_STALL) begin n_fail++; $display("FAIL load_use_ctrl_s: got %b expected %b", ctrl_s, V_STALL); end
    tick();
    // bubble in EX, load now in MEM completing this cycle
    @(negedge clk);
    ex_inst = 32'h0000_0013; ex_wren = 0; ex_mem_rd = 0;
    mem_inst = mk_inst(5, 1, 2); mem_wren = 1; mem_acc = 1; dmem_ready = 1;
    #1;
    n_checks++; if (ctrl_f !== V_IDLE) begin n_fail++; $display("FAIL load_use_one_bubble: got %b expected %b", ctrl_f, V_IDLE); end
    n_checks++; if (scnt_f !== 32'd1) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected 1", scnt_f); end
    n_checks++; if (ctrl_s !== V_STALL) begin n_fail++; $display("FAIL stall_only_mem_hit: got %b expected %b", ctrl_s, V_STALL); end
    n_checks++; if (scnt_s !== 4'd1) begin n_fail++; $display("FAIL stall_only_cnt: got %0d expected 1", scnt_s); end
    tick();
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive_idle();
    ex_inst = mk_inst(1, 3, 4); ex_rs1_en = 1; ex_rs2_en = 1;
    mem_inst = mk_inst(3, 0, 0); mem_wren = 1;
    wb_inst = mk_inst(3, 0, 0); wb_wren = 1;
    #1;
    n_checks++; if (ctrl_f !== {V_IDLE[10:4], 4'b0100}) begin n_fail++; $display("FAIL fwd_mem_priority: got %b expected %b", ctrl_f, {V_IDLE[10:4], 4'b0100}); end
    n_checks++; if (ctrl_s !== V_IDLE) begin n_fail++; $display("FAIL fwd_off_stall_only: got %b expected %b", ctrl_s, V_IDLE); end
    tick();
    @(negedge clk);
    ex_inst = mk_inst(1, 0, 0);
    mem_inst = mk_inst(0, 0, 0); wb_inst = mk_inst(0, 0, 0);
    #1;
    n_checks++; if (ctrl_f[3:0] !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0: got %b expected 0000", ctrl_f[3:0]); end
    tick();
    @(negedge clk);
    ex_inst = mk_inst(1, 3, 3);
    mem_inst = mk_inst(3, 0, 0); mem_wren = 0;
    wb_inst = mk_inst(3, 0, 0); wb_wren = 1;
    #1;
    n_checks++; if (ctrl_f[3:0] !== 4'b1010) begin n_fail++; $display("FAIL fwd_wb: got %b expected 1010", ctrl_f[3:0]); end
    tick();
  endtask

  task automatic test_stall_only();
    @(negedge clk);
    drive_idle();
    mem_inst = mk_inst(9, 0, 0); mem_wren = 1;
    id_inst = mk_inst(2, 1, 9); rs1_en = 0; rs2_en = 1;
    #1;
    n_checks++; if (ctrl_s !== V_STALL) begin n_fail++; $display("FAIL stall_only_rs2: got %b expected %b", ctrl_s, V_STALL); end
    n_checks++; if (ctrl_f !== V_IDLE) begin n_fail++; $display("FAIL fwd_no_stall_rs2: got %b expected %b", ctrl_f, V_IDLE); end
    tick();
    @(negedge clk);
    rs2_en = 0;
    #1;
    n_checks++; if (ctrl_s !== V_IDLE) begin n_fail++; $display("FAIL stall_only_rs2_off: got %b expected %b", ctrl_s, V_IDLE); end
    tick();
  endtask

  task automatic test_branch();
    longint base;
    base = fcnt_m[0];
    @(negedge clk);
    drive_idle(); drive_load_use(); br_taken = 1;
    #1;
    n_checks++; if (ctrl_f !== V_BRANCH) begin n_fail++; $display("FAIL branch_over_hazard_f: got %b expected %b", ctrl_f, V_BRANCH); end
    n_checks++; if (ctrl_s !== V_BRANCH) begin n_fail++; $display("FAIL branch_over_hazard_s: got %b expected %b", ctrl_s, V_BRANCH); end
    tick();
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++; if (fcnt_f !== 32'(base + 1)) begin n_fail++; $display("FAIL branch_flush_cnt: got %0d expected %0d", fcnt_f, base + 1); end
    n_checks++; if (ctrl_f !== V_IDLE) begin n_fail++; $display("FAIL branch_after: got %b expected %b", ctrl_f, V_IDLE); end
    tick();
  endtask

  task automatic test_mem_wait();
    longint fbase;
    fbase = fcnt_m[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_idle();
      mem_inst = mk_inst(8, 0, 0); mem_wren = 1; mem_acc = 1; dmem_ready = 0;
      br_taken = 1;   // branch parked in EX behind the wait
      #1;
      n_checks++; if (ctrl_f !== V_FREEZE) begin n_fail++; $display("FAIL wait_freeze[%0d]: got %b expected %b", i, ctrl_f, V_FREEZE); end
      n_checks++; if (to_f !== (i >= 5)) begin n_fail++; $display("FAIL wait_timeout[%0d]: got %b expected %b", i, to_f, (i >= 5)); end
      n_checks++; if (st_f !== (i >= 1)) begin n_fail++; $display("FAIL wait_state[%0d]: got %b expected %b", i, st_f, (i >= 1)); end
      n_checks++; if (to_s !== flag_m[1]) begin n_fail++; $display("FAIL wait_timeout_s[%0d]: got %b expected %b", i, to_s, flag_m[1]); end
      tick();
    end
    @(negedge clk);
    dmem_ready = 1;
    #1;
    n_checks++; if (ctrl_f !== V_BRANCH) begin n_fail++; $display("FAIL wait_release_branch: got %b expected %b", ctrl_f, V_BRANCH); end
    n_checks++; if (fcnt_f !== 32'(fbase)) begin n_fail++; $display("FAIL wait_no_flush_count: got %0d expected %0d", fcnt_f, fbase); end
    tick();
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++; if (st_f !== 1'b0) begin n_fail++; $display("FAIL wait_back_to_run: got %b expected 0", st_f); end
    n_checks++; if (to_f !== 1'b1) begin n_fail++; $display("FAIL wait_flag_sticky: got %b expected 1", to_f); end
    n_checks++; if (to_s !== 1'b1) begin n_fail++; $display("FAIL wait_flag_s_limit: got %b expected 1", to_s); end
    n_checks++; if (scnt_f !== 32'(scnt_m[0])) begin n_fail++; $display("FAIL wait_stall_cnt: got %0d expected %0d", scnt_f, scnt_m[0]); end
    n_checks++; if (ctrl_f !== V_IDLE) begin n_fail++; $display("FAIL wait_after_idle: got %b expected %b", ctrl_f, V_IDLE); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idle(); mem_acc = 1; dmem_ready = 0;
      tick();
    end
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++; if (ctrl_f !== V_RST) begin n_fail++; $display("FAIL midwait_rst_ctrl: got %b expected %b", ctrl_f, V_RST); end
    tick();
    @(negedge clk);
    rst = 0; drive_idle();
    #1;
    n_checks++; if (ctrl_f !== V_IDLE) begin n_fail++; $display("FAIL midwait_release_pc_en: got %b expected %b", ctrl_f, V_IDLE); end
    n_checks++; if (scnt_f !== 32'd0 || fcnt_f !== 32'd0) begin n_fail++; $display("FAIL midwait_counters: got %0d/%0d expected 0/0", scnt_f, fcnt_f); end
    n_checks++; if (to_f !== 1'b0 || to_s !== 1'b0) begin n_fail++; $display("FAIL midwait_flags: got %b/%b expected 0/0", to_f, to_s); end
    n_checks++; if (st_f !== 1'b0) begin n_fail++; $display("FAIL midwait_state: got %b expected 0", st_f); end
    tick();
  endtask

  task automatic test_random();
    int burst = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 63) == 0);
      id_inst    = mk_inst($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      ex_inst    = mk_inst($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      mem_inst   = mk_inst($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      wb_inst    = mk_inst($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      rs1_en     = 1'($urandom_range(0, 1));
      rs2_en     = 1'($urandom_range(0, 1));
      ex_wren    = 1'($urandom_range(0, 1));
      ex_rs1_en  = 1'($urandom_range(0, 1));
      ex_rs2_en  = 1'($urandom_range(0, 1));
      ex_mem_rd  = 1'($urandom_range(0, 1));
      mem_wren   = 1'($urandom_range(0, 1));
      wb_wren    = 1'($urandom_range(0, 1));
      br_taken   = ($urandom_range(0, 7) == 0);
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(3, 9);
      if (burst > 0) begin
        mem_acc = 1; dmem_ready = 0; burst--;
      end else begin
        mem_acc = ($urandom_range(0, 3) == 0);
        dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      exp_q.push_back(exp_ctrl(0));
      exp_q.push_back(exp_ctrl(1));
      for (int k = 0; k < 2; k++) begin
        logic [10:0] got_c, exp_c;
        logic [31:0] got_sc, got_fc;
        logic        got_to, got_st;
        if (k == 0) begin
          got_c = ctrl_f; got_sc = scnt_f; got_fc = fcnt_f; got_to = to_f; got_st = st_f;
        end else begin
          got_c = ctrl_s; got_sc = {28'd0, scnt_s}; got_fc = {28'd0, fcnt_s}; got_to = to_s; got_st = st_s;
        end
        exp_c = exp_q.pop_front();
        n_checks++; if (got_c !== exp_c) begin n_fail++; $display("FAIL rnd_ctrl[%0d] dut%0d: got %b expected %b", c, k, got_c, exp_c); end
        n_checks++; if (got_sc !== 32'(scnt_m[k])) begin n_fail++; $display("FAIL rnd_stall_cnt[%0d] dut%0d: got %0d expected %0d", c, k, got_sc, scnt_m[k]); end
        n_checks++; if (got_fc !== 32'(fcnt_m[k])) begin n_fail++; $display("FAIL rnd_flush_cnt[%0d] dut%0d: got %0d expected %0d", c, k, got_fc, fcnt_m[k]); end
        n_checks++; if (got_to !== flag_m[k]) begin n_fail++; $display("FAIL rnd_timeout[%0d] dut%0d: got %b expected %b", c, k, got_to, flag_m[k]); end
        n_checks++; if (got_st !== st_m[k]) begin n_fail++; $display("FAIL rnd_state[%0d] dut%0d: got %b expected %b", c, k, got_st, st_m[k]); end
      end
      tick();
    end
    @(negedge clk);
    rst = 0; drive_idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1;
    drive_idle();
    model_reset();
    test_reset();
    test_load_use();
    test_forward();
    test_stall_only();
    test_branch();
    test_mem_wait();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
